// File: rtl/popcount_frame_accumulator.sv
// Frame-level popcount accumulator: sums the set bits of a stream of words per frame
// and hands out one (total, words) result per frame on a valid/ready port.

module population_count #(
    parameter int WIDTH       = 32,
    parameter int COUNT_WIDTH = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0]       data,
    output logic [COUNT_WIDTH-1:0] count
);

    localparam int LEVELS = $clog2(WIDTH);
    localparam int LEAVES = 1 << LEVELS;

    logic [LEAVES-1:0] padded;

    generate
        if (LEAVES > WIDTH) begin : g_pad
            assign padded = {{(LEAVES - WIDTH){1'b0}}, data};
        end else begin : g_nopad
            assign padded = data;
        end
    endgenerate

    // Balanced adder tree; each level lives in its own scope so no net feeds back into itself.
    genvar gi, gj;
    generate
        for (gi = 0; gi <= LEVELS; gi++) begin : g_level
            localparam int NODES = LEAVES >> gi;
            logic [COUNT_WIDTH-1:0] sum [NODES];
            for (gj = 0; gj < NODES; gj++) begin : g_node
                if (gi == 0) begin : g_leaf
                    assign sum[gj] = COUNT_WIDTH'(padded[gj]);
                end else begin : g_add
                    assign sum[gj] = g_level[gi-1].sum[2*gj] + g_level[gi-1].sum[2*gj+1];
                end
            end
        end
    endgenerate

    assign count = g_level[LEVELS].sum[0];

endmodule

module popcount_frame_accumulator #(
    parameter int WORD_WIDTH  = 32,
    parameter int WORD_COUNT  = 16,
    parameter int TOTAL_WIDTH = 10
) (
    input  logic                             clock,
    input  logic                             clear,
    input  logic                             input_valid,
    output logic                             input_ready,
    input  logic [WORD_WIDTH-1:0]            input_data,
    input  logic                             input_last,
    output logic                             output_valid,
    input  logic                             output_ready,
    output logic [TOTAL_WIDTH-1:0]           output_total,
    output logic [$clog2(WORD_COUNT+1)-1:0]  output_words
);

    localparam int PC_W    = $clog2(WORD_WIDTH + 1);
    localparam int WORDS_W = $clog2(WORD_COUNT + 1);
    localparam logic [WORDS_W-1:0] LAST_INDEX = WORDS_W'(WORD_COUNT - 1);

    typedef enum logic {
        ACCUMULATE,
        HOLD
    } state_t;

    state_t state_reg, state_next;

    logic [PC_W-1:0]        word_popcount;
    logic                   word_last;
    logic                   in_fire;
    logic                   out_fire;
    logic [WORDS_W-1:0]     in_index_reg;
    logic                   s1_valid_reg;
    logic                   s1_last_reg;
    logic [PC_W-1:0]        s1_count_reg;
    logic                   s2_last_reg;
    logic [TOTAL_WIDTH-1:0] count_ext;
    logic [TOTAL_WIDTH-1:0] total_reg;
    logic [WORDS_W-1:0]     words_reg;

    population_count #(
        .WIDTH       (WORD_WIDTH),
        .COUNT_WIDTH (PC_W)
    ) u_popcount (
        .data  (input_data),
        .count (word_popcount)
    );

    generate
        if (TOTAL_WIDTH > PC_W) begin : g_ext
            assign count_ext = {{(TOTAL_WIDTH - PC_W){1'b0}}, s1_count_reg};
        end else if (TOTAL_WIDTH == PC_W) begin : g_same
            assign count_ext = s1_count_reg;
        end else begin : g_trunc
            assign count_ext = s1_count_reg[TOTAL_WIDTH-1:0];
        end
    endgenerate

    // The input-side index runs ahead of words_reg, so the forced last is decided at acceptance.
    assign word_last = input_last || (in_index_reg == LAST_INDEX);
    assign in_fire   = input_valid && input_ready;
    assign out_fire  = output_valid && output_ready;

    always_comb begin
        state_next   = state_reg;
        input_ready  = 1'b0;
        output_valid = 1'b0;
        case (state_reg)
            ACCUMULATE: begin
                input_ready = !clear && !(s1_valid_reg && s1_last_reg) && !s2_last_reg;
                if (s2_last_reg) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                output_valid = 1'b1;
                if (output_ready) begin
                    state_next = ACCUMULATE;
                end
            end
            default: state_next = ACCUMULATE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_reg <= ACCUMULATE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            in_index_reg <= '0;
            s1_valid_reg <= 1'b0;
            s1_last_reg  <= 1'b0;
            s1_count_reg <= '0;
            s2_last_reg  <= 1'b0;
            total_reg    <= '0;
            words_reg    <= '0;
        end else begin
            s1_valid_reg <= in_fire;
            if (in_fire) begin
                s1_count_reg <= word_popcount;
                s1_last_reg  <= word_last;
                in_index_reg <= word_last ? '0 : in_index_reg + 1'b1;
            end
            // Delays the frame end by one edge so HOLD starts two edges after the last accept.
            s2_last_reg <= s1_valid_reg && s1_last_reg;
            if (out_fire) begin
                total_reg <= '0;
                words_reg <= '0;
            end else if (s1_valid_reg) begin
                total_reg <= total_reg + count_ext;
                words_reg <= words_reg + 1'b1;
            end
        end
    end

    assign output_total = total_reg;
    assign output_words = words_reg;

endmodule

// File: tb/tb_popcount_frame_accumulator.sv
// Directed checks of framing, latency, backpressure and clear, followed by a random
// phase compared against a behavioural frame model.

module tb_popcount_frame_accumulator;

    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic        input_valid = 1'b0;
    logic        input_ready;
    logic [31:0] input_data = '0;
    logic        input_last = 1'b0;
    logic        output_valid;
    logic        output_ready = 1'b0;
    logic [9:0]  output_total;
    logic [4:0]  output_words;

    int vec_count = 0;
    int miss_count = 0;
    int cyc = 0;

    int res_total_q[$];
    int res_words_q[$];
    int exp_total_q[$];
    int exp_words_q[$];
    bit model_en = 1'b0;
    int m_total = 0;
    int m_words = 0;

    always #5 clock = ~clock;

    popcount_frame_accumulator #(
        .WORD_WIDTH  (32),
        .WORD_COUNT  (16),
        .TOTAL_WIDTH (10)
    ) dut (
        .clock        (clock),
        .clear        (clear),
        .input_valid  (input_valid),
        .input_ready  (input_ready),
        .input_data   (input_data),
        .input_last   (input_last),
        .output_valid (output_valid),
        .output_ready (output_ready),
        .output_total (output_total),
        .output_words (output_words)
    );

    // Collects DUT results and runs the reference frame model on accepted words.
    always @(posedge clock) begin : monitor
        int nt;
        int nw;
        cyc <= cyc + 1;
        if (clear) begin
            m_total <= 0;
            m_words <= 0;
        end else begin
            if (output_valid && output_ready) begin
                res_total_q.push_back(int'(output_total));
                res_words_q.push_back(int'(output_words));
            end
            if (input_valid && input_ready) begin
                nt = m_total + $countones(input_data);
                nw = m_words + 1;
                if (input_last || nw == 16) begin
                    if (model_en) begin
                        exp_total_q.push_back(nt % 1024);
                        exp_words_q.push_back(nw);
                    end
                    m_total <= 0;
                    m_words <= 0;
                end else begin
                    m_total <= nt;
                    m_words <= nw;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_count++;
        if (got !== exp) begin
            miss_count++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic send(input logic [31:0] d, input logic l);
        int waited = 0;
        input_valid = 1'b1;
        input_data  = d;
        input_last  = l;
        #1;
        while (!input_ready && waited < 40) begin
            @(negedge clock);
            #1;
            waited++;
        end
        if (!input_ready) check("send_ready", {31'b0, input_ready}, 1);
        @(negedge clock);
        input_valid = 1'b0;
        input_last  = 1'b0;
    endtask

    task automatic expect_result(input string tag, input int tot, input int wds);
        int waited = 0;
        int t;
        int w;
        while (res_total_q.size() == 0 && waited < 20) begin
            @(negedge clock);
            waited++;
        end
        check({tag, "_present"}, {31'b0, res_total_q.size() != 0}, 1);
        if (res_total_q.size() != 0) begin
            t = res_total_q.pop_front();
            w = res_words_q.pop_front();
            check({tag, "_total"}, t, tot);
            check({tag, "_words"}, w, wds);
            $display("frame %s: total=%0d words=%0d", tag, t, w);
        end
    endtask

    initial begin : stim
        int t0;
        int waited;
        int n_frames;

        // Reset state
        repeat (3) @(negedge clock);
        #1;
        check("rst_valid", {31'b0, output_valid}, 0);
        check("rst_total", {22'b0, output_total}, 0);
        check("rst_words", {27'b0, output_words}, 0);
        check("rst_ready", {31'b0, input_ready}, 0);
        @(negedge clock);
        clear = 1'b0;
        #1;
        check("ready_after_clear", {31'b0, input_ready}, 1);

        // 1: full frame of all-ones, latency and per-frame overhead
        output_ready = 1'b1;
        t0 = cyc;
        for (int i = 0; i < 16; i++) send(32'hFFFF_FFFF, 1'b0);
        check("t1_b2b_cycles", cyc - t0, 16);
        check("t1_valid_n1", {31'b0, output_valid}, 0);
        check("t1_ready_n1", {31'b0, input_ready}, 0);
        @(negedge clock);
        check("t1_valid_n2", {31'b0, output_valid}, 0);
        check("t1_ready_n2", {31'b0, input_ready}, 0);
        @(negedge clock);
        check("t1_valid_n3", {31'b0, output_valid}, 1);
        check("t1_total_n3", {22'b0, output_total}, 512);
        check("t1_words_n3", {27'b0, output_words}, 16);
        check("t1_ready_n3", {31'b0, input_ready}, 0);
        @(negedge clock);
        check("t1_valid_after_hs", {31'b0, output_valid}, 0);
        check("t1_ready_after_hs", {31'b0, input_ready}, 1);
        expect_result("t1", 512, 16);

        // 2: early end via input_last
        send(32'h0000_000F, 1'b0);
        send(32'h8000_0001, 1'b0);
        send(32'h0000_0000, 1'b1);
        expect_result("t2", 6, 3);

        // 3: single-word frames, no carry-over
        send(32'h0000_0000, 1'b1);
        expect_result("t3a", 0, 1);
        send(32'h0000_0001, 1'b1);
        expect_result("t3b", 1, 1);

        // 4: backpressure on the result port
        output_ready = 1'b0;
        send(32'h0000_00FF, 1'b0);
        send(32'h0000_FF00, 1'b1);
        waited = 0;
        while (!output_valid && waited < 10) begin
            @(negedge clock);
            waited++;
        end
        check("t4_valid_rise", {31'b0, output_valid}, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check("t4_hold_valid", {31'b0, output_valid}, 1);
            check("t4_hold_total", {22'b0, output_total}, 16);
            check("t4_hold_words", {27'b0, output_words}, 2);
            check("t4_hold_ready", {31'b0, input_ready}, 0);
        end
        output_ready = 1'b1;
        @(negedge clock);
        check("t4_valid_after_hs", {31'b0, output_valid}, 0);
        check("t4_ready_after_hs", {31'b0, input_ready}, 1);
        expect_result("t4", 16, 2);

        // 5: clear aborts a partial frame
        for (int i = 0; i < 5; i++) send(32'hFFFF_0000, 1'b0);
        clear = 1'b1;
        #1;
        check("t5_ready_in_clear", {31'b0, input_ready}, 0);
        @(negedge clock);
        clear = 1'b0;
        #1;
        check("t5_ready_after_clear", {31'b0, input_ready}, 1);
        check("t5_total_cleared", {22'b0, output_total}, 0);
        check("t5_words_cleared", {27'b0, output_words}, 0);
        send(32'h0000_0003, 1'b1);
        expect_result("t5", 2, 1);
        repeat (5) @(negedge clock);
        check("t5_no_extra", res_total_q.size(), 0);

        // 6: random traffic against the frame model
        model_en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            input_valid = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0:       input_data = 32'h0;
                1:       input_data = 32'hFFFF_FFFF;
                2:       input_data = $urandom;
                default: input_data = 32'h1 << $urandom_range(0, 31);
            endcase
            input_last   = ($urandom_range(0, 7) == 0);
            output_ready = ($urandom_range(0, 3) != 0);
            @(negedge clock);
        end
        input_valid  = 1'b0;
        output_ready = 1'b1;
        send($urandom, 1'b1);
        repeat (10) @(negedge clock);
        model_en = 1'b0;
        n_frames = exp_total_q.size();
        check("t6_frame_count", res_total_q.size(), n_frames);
        while (res_total_q.size() != 0 && exp_total_q.size() != 0) begin
            check("t6_total", res_total_q.pop_front(), exp_total_q.pop_front());
            check("t6_words", res_words_q.pop_front(), exp_words_q.pop_front());
        end
        $display("random phase: %0d frames compared", n_frames);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
